// File: rtl/bus_ctrl.sv
// Front-panel bus controller: debounces go, applies sel-addressed control writes, owns the system bus.
// Optional multiple-driver rejection is enabled by defining BUS_CONFLICT_CHECK_EN.
module bus_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NMOD    = 10,
    parameter int SELW    = 4,
    parameter int DB_BITS = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [SELW-1:0]         sel,
    input  logic                    go,
    input  logic                    en,
    input  logic                    OE,
    input  logic                    WE,
    input  logic                    load,
    input  logic                    HLT,
    input  logic [WIDTH-1:0]        in,
    input  logic [NMOD*WIDTH-1:0]   src_data,
    output logic [NMOD-1:0]         en_vec,
    output logic [NMOD-1:0]         oe_vec,
    output logic [NMOD-1:0]         we_vec,
    output logic [NMOD-1:0]         load_vec,
    output logic [WIDTH-1:0]        Bus_out,
    output logic                    cmd_ack,
    output logic                    cmd_err,
    output logic                    conflict
);

    localparam logic [SELW-1:0] NMOD_SEL = SELW'(NMOD);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT_REL} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [DB_BITS-1:0]   r_db_cnt;
    logic                 r_go_db;
    logic                 r_go_db_d;
    logic [WIDTH-1:0]     r_bus;
    logic                 r_ack;
    logic                 r_err;
    logic                 w_go_rise;
    logic                 w_apply;
    logic                 w_hit_mod;
    logic                 w_reject;
    logic                 w_mod_wr;
    logic                 w_bus_ld;
    logic                 w_any_oe;
    logic [WIDTH-1:0]     w_bus_src;
    logic [NMOD-1:0]      w_tgt;
    logic [NMOD-1:0]      w_oe_vec;

    // Two-flop synchroniser followed by a stability counter on go.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_go_db   <= 1'b0;
            r_go_db_d <= 1'b0;
        end else begin
            r_sync1   <= go;
            r_sync2   <= r_sync1;
            r_go_db_d <= r_go_db;
            if (r_sync2 == r_go_db) begin
                r_db_cnt <= '0;
            end else if (&r_db_cnt) begin
                r_go_db  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_BITS'(1);
            end
        end
    end

    assign w_go_rise = r_go_db & ~r_go_db_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_go_rise) w_state_next = S_APPLY;
            S_APPLY:    w_state_next = S_WAIT_REL;
            S_WAIT_REL: if (!r_go_db) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        if (HLT) w_state_next = S_IDLE;
    end

    // Bus source: lowest-index channel with OE set wins.
    always_comb begin
        w_bus_src = '0;
        w_any_oe  = |w_oe_vec;
        for (int i = NMOD - 1; i >= 0; i--) begin
            if (w_oe_vec[i]) w_bus_src = src_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef BUS_CONFLICT_CHECK_EN
    logic r_conflict;
    assign w_reject = w_hit_mod & OE & ~WE & (|(w_oe_vec & ~w_tgt));
    assign conflict = r_conflict;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                    r_conflict <= 1'b0;
        else if (HLT)                 r_conflict <= 1'b0;
        else if (w_apply && w_reject) r_conflict <= 1'b1;
    end
`else
    assign w_reject = 1'b0;
    assign conflict = 1'b0;
`endif

    assign w_apply   = (r_state == S_APPLY) & ~HLT;
    assign w_hit_mod = (sel < NMOD_SEL);
    assign w_mod_wr  = w_apply & w_hit_mod & ~w_reject;
    assign w_bus_ld  = w_apply & (sel == NMOD_SEL) & load;

    genvar gi;
    generate
        for (gi = 0; gi < NMOD; gi++) begin : g_chan
            logic r_en;
            logic r_oe;
            logic r_we;
            logic r_ld;

            assign w_tgt[gi] = (sel == SELW'(gi));

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET || HLT) begin
                    r_en <= 1'b0;
                    r_oe <= 1'b0;
                    r_we <= 1'b0;
                    r_ld <= 1'b0;
                end else if (w_mod_wr && w_tgt[gi]) begin
                    // WE wins: a channel being written never drives or loads.
                    r_en <= en;
                    r_we <= WE;
                    r_oe <= OE & ~WE;
                    r_ld <= load & ~WE;
                end
            end

            assign en_vec[gi]   = r_en;
            assign w_oe_vec[gi] = r_oe;
            assign we_vec[gi]   = r_we;
            assign load_vec[gi] = r_ld;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bus <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_mod_wr | w_bus_ld;
            r_err <= w_apply & ~(w_mod_wr | w_bus_ld);
            if (!HLT) begin
                if (w_bus_ld)      r_bus <= in;
                else if (w_any_oe) r_bus <= w_bus_src;
            end
        end
    end

    assign oe_vec  = w_oe_vec;
    assign Bus_out = r_bus;
    assign cmd_ack = r_ack;
    assign cmd_err = r_err;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: cycle model of the controller rules plus directed front-panel scenarios.
module tb_bus_ctrl;
    localparam int WIDTH   = 8;
    localparam int NMOD    = 4;
    localparam int SELW    = 4;
    localparam int DB_BITS = 2;
`ifdef BUS_CONFLICT_CHECK_EN
    localparam bit CC = 1'b1;
`else
    localparam bit CC = 1'b0;
`endif

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic [SELW-1:0]       sel;
    logic                  go, en, OE, WE, load, HLT;
    logic [WIDTH-1:0]      in_data;
    logic [NMOD*WIDTH-1:0] src_data;
    logic [NMOD-1:0]       en_vec, oe_vec, we_vec, load_vec;
    logic [WIDTH-1:0]      Bus_out;
    logic                  cmd_ack, cmd_err, conflict;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    bus_ctrl #(.WIDTH(WIDTH), .NMOD(NMOD), .SELW(SELW), .DB_BITS(DB_BITS)) dut (
        .CLK(CLK), .RESET(RESET), .sel(sel), .go(go), .en(en), .OE(OE), .WE(WE),
        .load(load), .HLT(HLT), .in(in_data), .src_data(src_data),
        .en_vec(en_vec), .oe_vec(oe_vec), .we_vec(we_vec), .load_vec(load_vec),
        .Bus_out(Bus_out), .cmd_ack(cmd_ack), .cmd_err(cmd_err), .conflict(conflict)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: state of the panel as the rules describe it.
    logic [1:0]       m_sync;
    logic             m_go_db, m_go_db_d;
    int               m_run, m_phase;   // phase: 0 idle, 1 applying, 2 waiting for release
    logic [NMOD-1:0]  m_en, m_oe, m_we, m_ld;
    logic [WIDTH-1:0] m_bus;
    logic             m_ack, m_err, m_conf;

    always @(posedge CLK or posedge RESET) begin : model
        logic [NMOD-1:0]  n_en, n_oe, n_we, n_ld;
        logic [WIDTH-1:0] n_bus;
        logic             n_ack, n_err, n_conf, n_go_db, others;
        int               n_run, n_phase, low, s;
        if (RESET) begin
            m_sync <= '0; m_go_db <= 1'b0; m_go_db_d <= 1'b0; m_run <= 0; m_phase <= 0;
            m_en <= '0; m_oe <= '0; m_we <= '0; m_ld <= '0; m_bus <= '0;
            m_ack <= 1'b0; m_err <= 1'b0; m_conf <= 1'b0;
        end else begin
            n_en = m_en; n_oe = m_oe; n_we = m_we; n_ld = m_ld;
            n_bus = m_bus; n_conf = m_conf; n_ack = 1'b0; n_err = 1'b0;
            low = -1;
            for (int i = 0; i < NMOD; i++) if (m_oe[i] && low < 0) low = i;
            if (HLT) begin
                n_en = '0; n_oe = '0; n_we = '0; n_ld = '0; n_conf = 1'b0;
            end else begin
                if (low >= 0) n_bus = src_data[low*WIDTH +: WIDTH];
                if (m_phase == 1) begin
                    s = int'(sel);
                    if (s < NMOD) begin
                        others = 1'b0;
                        for (int j = 0; j < NMOD; j++) if (j != s && m_oe[j]) others = 1'b1;
                        if (CC && OE && !WE && others) begin
                            n_err = 1'b1; n_conf = 1'b1;
                        end else begin
                            n_en[s] = en; n_we[s] = WE;
                            n_oe[s] = OE && !WE; n_ld[s] = load && !WE;
                            n_ack = 1'b1;
                        end
                    end else if (s == NMOD && load) begin
                        n_bus = in_data; n_ack = 1'b1;
                    end else begin
                        n_err = 1'b1;
                    end
                end
            end
            if (HLT)              n_phase = 0;
            else if (m_phase == 0) n_phase = (m_go_db && !m_go_db_d) ? 1 : 0;
            else if (m_phase == 1) n_phase = 2;
            else                  n_phase = m_go_db ? 2 : 0;
            n_go_db = m_go_db;
            n_run   = 0;
            if (m_sync[1] != m_go_db) begin
                n_run = m_run + 1;
                if (n_run == (1 << DB_BITS)) begin
                    n_go_db = m_sync[1];
                    n_run = 0;
                end
            end
            m_sync <= {m_sync[0], go};
            m_go_db_d <= m_go_db; m_go_db <= n_go_db; m_run <= n_run; m_phase <= n_phase;
            m_en <= n_en; m_oe <= n_oe; m_we <= n_we; m_ld <= n_ld; m_bus <= n_bus;
            m_ack <= n_ack; m_err <= n_err; m_conf <= n_conf;
        end
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            check("en_vec",   en_vec,   m_en);
            check("oe_vec",   oe_vec,   m_oe);
            check("we_vec",   we_vec,   m_we);
            check("load_vec", load_vec, m_ld);
            check("Bus_out",  Bus_out,  m_bus);
            check("cmd_ack",  cmd_ack,  m_ack);
            check("cmd_err",  cmd_err,  m_err);
            check("conflict", conflict, m_conf);
        end
        if (cmd_ack) ack_cnt++;
        if (cmd_err) err_cnt++;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_cmd(input logic [SELW-1:0] s, input logic e, input logic o,
                           input logic w, input logic l, input logic [WIDTH-1:0] d);
        sel = s; en = e; OE = o; WE = w; load = l; in_data = d;
    endtask

    task automatic start_cmd(input logic [SELW-1:0] s, input logic e, input logic o,
                             input logic w, input logic l, input logic [WIDTH-1:0] d);
        set_cmd(s, e, o, w, l, d);
        go = 1'b1;
        repeat (8) tick();
    endtask

    task automatic finish_cmd();
        repeat (4) tick();
        go = 1'b0;
        repeat (10) tick();
    endtask

    int a0, e0;

    initial begin
        RESET = 1'b1; go = 1'b0; HLT = 1'b0;
        set_cmd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        src_data = {8'h96, 8'hC3, 8'h5A, 8'h3C};
        repeat (3) tick();
        check("rst_bus", Bus_out, 8'h00);
        check("rst_vecs", {en_vec, oe_vec, we_vec, load_vec}, 16'h0000);
        check("rst_flags", {cmd_ack, cmd_err, conflict}, 3'b000);
        RESET = 1'b0;
        repeat (2) tick();

        // Bouncy press on ch1 with OE
        a0 = ack_cnt;
        set_cmd(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        go = 1'b1; tick(); go = 1'b0; tick(); go = 1'b1;
        repeat (7) tick();
        check("bounce_oe_early", oe_vec, 4'b0000);
        tick();
        check("bounce_oe", oe_vec, 4'b0010);
        check("bounce_ack", ack_cnt - a0, 1);
        finish_cmd();
        check("bounce_one_cmd", ack_cnt - a0, 1);
        check("bus_src1", Bus_out, 8'h5A);

        // WE priority on ch2
        start_cmd(4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        check("we_vec", we_vec, 4'b0100);
        check("we_oe", oe_vec, 4'b0010);
        check("we_load", load_vec, 4'b0000);
        check("we_en", en_vec, 4'b0100);
        finish_cmd();

        // Clear ch1 OE, then load bus from switches
        start_cmd(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        finish_cmd();
        a0 = ack_cnt;
        start_cmd(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        check("busld_val", Bus_out, 8'hA5);
        check("busld_ack", ack_cnt - a0, 1);
        finish_cmd();
        check("busld_hold", Bus_out, 8'hA5);

        // Ch0 drives: bus follows one cycle after oe_vec[0]
        start_cmd(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("oe0_set", oe_vec, 4'b0001);
        check("oe0_bus_old", Bus_out, 8'hA5);
        tick();
        check("oe0_bus_new", Bus_out, 8'h3C);
        finish_cmd();

        // Out-of-range select
        a0 = ack_cnt; e0 = err_cnt;
        start_cmd(4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        check("sel7_err", err_cnt - e0, 1);
        check("sel7_noack", ack_cnt - a0, 0);
        check("sel7_vecs", {en_vec, oe_vec, we_vec, load_vec}, 16'h4140);
        finish_cmd();

        // Two drivers: ch1 then ch3
        start_cmd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        finish_cmd();
        start_cmd(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        finish_cmd();
        a0 = ack_cnt; e0 = err_cnt;
        start_cmd(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
`ifdef BUS_CONFLICT_CHECK_EN
        check("conf_err", err_cnt - e0, 1);
        check("conf_flag", conflict, 1'b1);
        check("conf_oe", oe_vec, 4'b0010);
`else
        check("noconf_ack", ack_cnt - a0, 1);
        check("noconf_oe", oe_vec, 4'b1010);
        tick();
        check("noconf_bus", Bus_out, 8'h5A);
`endif
        finish_cmd();

        // Halt during APPLY discards the command
        a0 = ack_cnt; e0 = err_cnt;
        set_cmd(4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        go = 1'b1;
        repeat (7) tick();
        HLT = 1'b1;
        src_data[15:8] = 8'h11;
        tick();
        check("hlt_vecs", {en_vec, oe_vec, we_vec, load_vec}, 16'h0000);
        check("hlt_bus", Bus_out, 8'h5A);
        check("hlt_conf", conflict, 1'b0);
        HLT = 1'b0;
        src_data[15:8] = 8'h5A;
        finish_cmd();
        check("hlt_noack", ack_cnt - a0, 0);
        check("hlt_noerr", err_cnt - e0, 0);

        // Asynchronous reset mid-debounce
        start_cmd(4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        finish_cmd();
        check("pre_rst_en", en_vec, 4'b0010);
        go = 1'b1;
        repeat (3) tick();
        #2 RESET = 1'b1;
        #1;
        check("arst_bus", Bus_out, 8'h00);
        check("arst_vecs", {en_vec, oe_vec, we_vec, load_vec}, 16'h0000);
        check("arst_flags", {cmd_ack, cmd_err, conflict}, 3'b000);
        go = 1'b0;
        tick();
        RESET = 1'b0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
